// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO controllers: Gray/binary pointer
// conversion and the read-side output buffer state encoding.
package fifo_pkg;

  localparam int FIFO_FN_W = 32;

  typedef logic [FIFO_FN_W-1:0] fifo_word_t;

  // Occupancy of the two-entry head/skid output buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  // Zero-extended operands convert correctly at any narrower width, so callers
  // cast their pointer up to FIFO_FN_W and the result back down.
  function automatic fifo_word_t bin2gray(input fifo_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic fifo_word_t gray2bin(input fifo_word_t g);
    fifo_word_t b;
    b[FIFO_FN_W-1] = g[FIFO_FN_W-1];
    for (int i = FIFO_FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains;
// every stage clears to zero on reset.
module sync_ff #(
  parameter int STAGES = 2,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: read pointer, empty/level from the
// synchronized write pointer, RAM read issue and a FWFT valid/ready output buffer.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            rd_clk,
  input  logic            rd_rst,
  input  logic [ADDR_W:0] wr_ptr_gray,
  output logic [ADDR_W:0] rd_ptr_gray,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic            rd_en,
  input  logic [W-1:0]    rd_data,
  output logic [W-1:0]    dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            empty,
  output logic [ADDR_W:0] rd_level
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wq;
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] rd_bin_p0;
  logic [PW-1:0] rd_bin_nxt;
  logic [PW-1:0] rd_gray_nxt;

  logic          vld_p0;
  logic          vld_p1;
  logic          pop;

  buf_state_t    occ_q;
  buf_state_t    occ_nxt;
  logic          head_ld;
  logic          head_from_skid;
  logic          skid_ld;
  logic [W-1:0]  head_q;
  logic [W-1:0]  skid_q;

  sync_ff #(
    .STAGES (SYNC_STAGES),
    .DATA_W (PW)
  ) u_wq_sync (
    .clk (rd_clk),
    .rst (rd_rst),
    .d   (wr_ptr_gray),
    .q   (wq)
  );

  assign wq_bin      = PW'(gray2bin(FIFO_FN_W'(wq)));
  assign rd_bin_nxt  = rd_bin_p0 + PW'(vld_p0);
  assign rd_gray_nxt = PW'(bin2gray(FIFO_FN_W'(rd_bin_nxt)));

  assign pop        = dout_valid & dout_ready;
  assign dout_valid = (occ_q != BUF_EMPTY);
  assign dout       = head_q;

  // p0: issue. occ_nxt is occ + infl - pop, so a read is allowed whenever the
  // buffer would not be full after this cycle's landing and pop.
  assign vld_p0 = !empty && (occ_nxt != BUF_TWO);
  assign rd_en  = vld_p0;
  assign rd_ptr = rd_bin_p0[ADDR_W-1:0];

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin_p0   <= '0;
      rd_ptr_gray <= '0;
      empty       <= 1'b1;
      rd_level    <= '0;
      vld_p1      <= 1'b0;
    end else begin
      rd_bin_p0   <= rd_bin_nxt;
      rd_ptr_gray <= rd_gray_nxt;
      empty       <= (rd_gray_nxt == wq);
      rd_level    <= wq_bin - rd_bin_nxt;
      vld_p1      <= vld_p0;
    end
  end

  // p1: landing. rd_data from last cycle's read goes to head when the head is
  // free or leaving, otherwise to skid; a pop with a full buffer promotes skid.
  always_comb begin
    occ_nxt        = occ_q;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (occ_q)
      BUF_EMPTY: begin
        if (vld_p1) begin
          occ_nxt = BUF_ONE;
          head_ld = 1'b1;
        end
      end
      BUF_ONE: begin
        if (vld_p1 && pop) begin
          head_ld = 1'b1;
        end else if (vld_p1) begin
          occ_nxt = BUF_TWO;
          skid_ld = 1'b1;
        end else if (pop) begin
          occ_nxt = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          occ_nxt        = BUF_ONE;
          head_ld        = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: begin
        occ_nxt = BUF_EMPTY;
      end
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      occ_q <= BUF_EMPTY;
    end else begin
      occ_q <= occ_nxt;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_ld) begin
        head_q <= head_from_skid ? skid_q : rd_data;
      end
      if (skid_ld) begin
        skid_q <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural write side and RAM, scoreboard of written
// words checked by a monitor on every accepted output word.
module tb_fifo_rd_ctrl;

  localparam int ADDR_W      = 4;
  localparam int W           = 8;
  localparam int SYNC_STAGES = 2;
  localparam int PW          = ADDR_W + 1;

  logic              rd_clk = 1'b0;
  logic              rd_rst = 1'b1;
  logic [PW-1:0]     wr_ptr_gray = '0;
  logic [PW-1:0]     rd_ptr_gray;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_en;
  logic [W-1:0]      rd_data = '0;
  logic [W-1:0]      dout;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic              empty;
  logic [PW-1:0]     rd_level;

  fifo_rd_ctrl #(
    .ADDR_W      (ADDR_W),
    .W           (W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .rd_ptr      (rd_ptr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .empty       (empty),
    .rd_level    (rd_level)
  );

  always #5 rd_clk = ~rd_clk;

  logic [W-1:0] mem [16];
  always @(posedge rd_clk) begin
    if (rd_en) rd_data <= mem[rd_ptr];
  end

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] sb [$];
  logic [PW-1:0] wr_bin = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    mem[wr_bin[ADDR_W-1:0]] = d;
    wr_bin      = wr_bin + 1'b1;
    wr_ptr_gray = wr_bin ^ (wr_bin >> 1);
    sb.push_back(d);
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  // monitor: scoreboard pops and per-cycle invariants
  int rd_cnt  = 0;
  int wraps   = 0;
  int msb_tog = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  bit have_last = 1'b0;
  logic [PW-1:0] prev_gray = '0;

  always @(negedge rd_clk) begin
    if (rd_rst) begin
      prev_gray = '0;
      have_last = 1'b0;
    end else begin
      if (dout_valid && dout_ready) begin
        check("pop_has_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) check("dout_data", 32'(dout), 32'(sb.pop_front()));
      end
      if (rd_en) begin
        rd_cnt++;
        if (have_last && last_addr == 4'd15 && rd_ptr == 4'd0) wraps++;
        last_addr = rd_ptr;
        have_last = 1'b1;
        check("rd_en_while_empty", 32'(empty), 32'd0);
      end
      if (rd_ptr_gray != prev_gray) begin
        check("gray_one_bit", 32'($countones(rd_ptr_gray ^ prev_gray)), 32'd1);
        if (rd_ptr_gray[PW-1] != prev_gray[PW-1]) msb_tog++;
        prev_gray = rd_ptr_gray;
      end
      check("level_max", 32'(rd_level <= 16), 32'd1);
    end
  end

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!dout_valid && n < bound) begin
      tick();
      n++;
    end
    check("wait_valid_timeout", 32'(dout_valid), 32'd1);
  endtask

  logic [15:0] pat = 16'b1011_0111_1101_1110;

  task automatic wait_drain(input int bound, input bit use_pat);
    int n = 0;
    while ((sb.size() != 0 || dout_valid || rd_en) && n < bound) begin
      if (use_pat) dout_ready = pat[n % 16];
      tick();
      n++;
    end
    dout_ready = 1'b1;
    check("drain_timeout", 32'(sb.size() == 0 && !dout_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, tg0;
    // reset state
    repeat (3) tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_ptr_gray", 32'(rd_ptr_gray), 32'd0);
    check("rst_rd_level", 32'(rd_level), 32'd0);
    rd_rst = 1'b0;
    repeat (2) tick();
    check("idle_empty", 32'(empty), 32'd1);

    // single word: visible after SYNC_STAGES+1 edges, data 2 edges after rd_en
    push(8'hA5);
    tick();
    tick();
    check("single_empty_pre", 32'(empty), 32'd1);
    tick();
    check("single_empty", 32'(empty), 32'd0);
    check("single_rd_en", 32'(rd_en), 32'd1);
    check("single_rd_ptr", 32'(rd_ptr), 32'd0);
    check("single_level", 32'(rd_level), 32'd1);
    tick();
    check("single_rd_en_off", 32'(rd_en), 32'd0);
    check("single_valid_early", 32'(dout_valid), 32'd0);
    tick();
    check("single_valid", 32'(dout_valid), 32'd1);
    check("single_dout", 32'(dout), 32'hA5);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("single_valid_after", 32'(dout_valid), 32'd0);
    check("single_empty_after", 32'(empty), 32'd1);
    check("single_gray", 32'(rd_ptr_gray), 32'd1);

    // streaming 16 words with the consumer always ready
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    wait_valid(20);
    for (int i = 0; i < 16; i++) begin
      check("stream_no_gap", 32'(dout_valid), 32'd1);
      tick();
    end
    check("stream_done_valid", 32'(dout_valid), 32'd0);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // backpressure: only two reads may be issued while the consumer stalls
    dout_ready = 1'b0;
    rd0 = rd_cnt;
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dout_valid) check("bp_dout_stable", 32'(dout), 32'h40);
    end
    check("bp_reads", 32'(rd_cnt - rd0), 32'd2);
    check("bp_level", 32'(rd_level), 32'd6);
    check("bp_valid", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    wait_drain(40, 1'b0);

    // wrap: 40 words from read pointer 25, irregular consumer
    wr0 = wraps;
    tg0 = msb_tog;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) push(8'(8'h80 + b * 8 + i));
      wait_drain(100, 1'b1);
    end
    check("wrap_rd_ptr_count", 32'(wraps - wr0), 32'd3);
    check("wrap_msb_toggles", 32'(msb_tog - tg0), 32'd3);
    check("wrap_final_gray", 32'(rd_ptr_gray), 32'd1);

    // reset with a buffered word and a read in flight
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    wait_valid(20);
    #2;
    rd_rst      = 1'b1;
    wr_bin      = '0;
    wr_ptr_gray = '0;
    sb.delete();
    #1;
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_gray", 32'(rd_ptr_gray), 32'd0);
    check("mid_rst_rd_ptr", 32'(rd_ptr), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_level", 32'(rd_level), 32'd0);
    check("mid_rst_rd_en", 32'(rd_en), 32'd0);
    tick();
    tick();
    rd_rst = 1'b0;
    tick();
    push(8'h5A);
    dout_ready = 1'b1;
    wait_drain(30, 1'b0);
    check("post_rst_empty", 32'(empty), 32'd1);
    check("post_rst_gray", 32'(rd_ptr_gray), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
